// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU scheduler: FSM states, ALU op codes
// and the width of the op-select field.
package alu_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_ABSDIFF = 3'd1,
        OP_GT      = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_XOR     = 3'd5,
        OP_PASS_A  = 3'd6,
        OP_PASS_B  = 3'd7
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational unsigned ALU. sel codes 8..15 pass A through and flag err.
module alu
    import alu_pkg::*;
#(
    parameter int width = 5
) (
    input  logic [width:0]     a,
    input  logic [width:0]     b,
    input  logic [SEL_W-1:0]   sel,
    output logic [width:0]     x,
    output logic               err
);

    function automatic logic [width:0] abs_diff(input logic [width:0] p, input logic [width:0] q);
        return (p >= q) ? (p - q) : (q - p);
    endfunction

    always_comb begin
        x   = a;
        err = sel[SEL_W-1];
        if (!sel[SEL_W-1]) begin
            case (alu_op_t'(sel[2:0]))
                OP_ADD:     x = a + b;
                OP_ABSDIFF: x = abs_diff(a, b);
                OP_GT:      x = {{width{1'b0}}, (a > b)};
                OP_AND:     x = a & b;
                OP_OR:      x = a | b;
                OP_XOR:     x = a ^ b;
                OP_PASS_A:  x = a;
                OP_PASS_B:  x = b;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches ptr+1, ptr+2, ... modulo NREQ and grants the
// first valid request. Grant is one-hot or zero; nothing is granted when en=0.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NREQ requesters: round-robin grant in IDLE, operands
// latched on accept, result registered in EXEC and held in RESP until taken.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int width = 5,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NREQ-1:0]           i_req_valid,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic [NREQ*(width+1)-1:0] i_req_A,
    input  logic [NREQ*(width+1)-1:0] i_req_B,
    input  logic [NREQ*SEL_W-1:0]     i_req_sel,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [width:0]            o_rsp_X,
    output logic [IDW-1:0]            o_rsp_id,
    output logic                      o_rsp_err,
    output logic                      o_busy
);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   winner;
    logic             arb_en;

    logic [width:0]   op_a_p0;
    logic [width:0]   op_b_p0;
    logic [SEL_W-1:0] op_sel_p0;
    logic [IDW-1:0]   op_id_p0;

    logic [width:0]   alu_x;
    logic             alu_err;

    // Gate with reset so no requester sees ready while reset is asserted.
    assign arb_en      = (state == IDLE) && i_rst_n;
    assign o_req_ready = grant;
    assign o_busy      = (state != IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (i_req_valid),
        .ptr    (rr_ptr),
        .en     (arb_en),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            rr_ptr <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && |grant) rr_ptr <= winner;
        end
    end

    // Stage p0: operands of the granted requester, frozen for the whole op.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && |grant) begin
            op_a_p0   <= i_req_A[int'(winner)*(width+1) +: (width+1)];
            op_b_p0   <= i_req_B[int'(winner)*(width+1) +: (width+1)];
            op_sel_p0 <= i_req_sel[int'(winner)*SEL_W +: SEL_W];
            op_id_p0  <= winner;
        end
    end

    alu #(.width(width)) u_alu (
        .a   (op_a_p0),
        .b   (op_b_p0),
        .sel (op_sel_p0),
        .x   (alu_x),
        .err (alu_err)
    );

    // Stage p1: response register, held under back-pressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_X     <= '0;
            o_rsp_id    <= '0;
            o_rsp_err   <= 1'b0;
        end else if (state == EXEC) begin
            o_rsp_valid <= 1'b1;
            o_rsp_X     <= alu_x;
            o_rsp_id    <= op_id_p0;
            o_rsp_err   <= alu_err;
        end else if (state == RESP && i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed-vector bench for alu_rr_scheduler (width=5, NREQ=4).
module tb_alu_rr_scheduler;

    localparam int W    = 6;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_x;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.width(5), .NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_A     (req_a),
        .i_req_B     (req_b),
        .i_req_sel   (req_sel),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_X     (rsp_x),
        .o_rsp_id    (rsp_id),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input int a, input int b, input int s);
        logic [31:0] av, bv, sv;
        av = a; bv = b; sv = s;
        req_a[k*W +: W]   = av[W-1:0];
        req_b[k*W +: W]   = bv[W-1:0];
        req_sel[k*4 +: 4] = sv[3:0];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_x"}, 32'(rsp_x), 0);
        check({tag, "_id"}, 32'(rsp_id), 0);
        check({tag, "_err"}, 32'(rsp_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One isolated transaction from IDLE; input bus is scrambled after accept.
    task automatic issue(input string tag, input int k, input int a, input int b, input int s,
                         input int exp_x, input int exp_err);
        set_op(k, a, b, s);
        req_valid = '0;
        req_valid[k] = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << k));
        step();
        req_valid = '0;
        set_op(k, 42, 17, 5);
        check({tag, "_busy_exec"}, 32'(busy), 1);
        check({tag, "_valid_exec"}, 32'(rsp_valid), 0);
        step();
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        check({tag, "_x"}, 32'(rsp_x), 32'(exp_x));
        check({tag, "_id"}, 32'(rsp_id), 32'(k));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        step();
        check({tag, "_valid_drop"}, 32'(rsp_valid), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    int order [8] = '{0, 1, 2, 3, 0, 2, 3, 0};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // T1 / T2 / T5: single transactions
        issue("t1_add", 0, 3, 4, 0, 7, 0);
        issue("t2_absdiff", 2, 5, 9, 1, 4, 0);
        issue("t2_gt_true", 2, 9, 5, 2, 1, 0);
        issue("t2_gt_false", 2, 5, 9, 2, 0, 0);
        issue("and", 1, 6'b101101, 6'b011011, 3, 6'b001001, 0);
        issue("xor", 3, 6'b101101, 6'b011011, 5, 6'b110110, 0);
        issue("pass_b", 1, 12, 34, 7, 34, 0);
        issue("t5_illegal", 1, 21, 7, 12, 21, 1);

        // T3: contention, requester 1 dropped after the fifth grant
        do_reset();
        for (int k = 0; k < NREQ; k++) set_op(k, k, 10, 0);
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            if (j == 5) req_valid = 4'b1101;
            #1;
            check($sformatf("t3_grant%0d", j), 32'(req_ready), 32'(1 << order[j]));
            step();
            step();
            check($sformatf("t3_id%0d", j), 32'(rsp_id), 32'(order[j]));
            check($sformatf("t3_x%0d", j), 32'(rsp_x), 32'(order[j] + 10));
            step();
        end
        req_valid = '0;
        step();

        // T4: overflow plus back-pressure
        set_op(3, 63, 1, 0);
        req_valid = 4'b1000;
        #1;
        check("t4_ready", 32'(req_ready), 32'b1000);
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4_hold_valid%0d", c), 32'(rsp_valid), 1);
            check($sformatf("t4_hold_x%0d", c), 32'(rsp_x), 0);
            check($sformatf("t4_hold_id%0d", c), 32'(rsp_id), 3);
            check($sformatf("t4_hold_ready%0d", c), 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        check("t4_released", 32'(rsp_valid), 0);

        // T6: reset while in EXEC; pointer was moved to 0 beforehand
        set_op(0, 11, 12, 0);
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1111;
        check("t6_in_exec", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_reset");
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t6_no_rsp%0d", c), 32'(rsp_valid), 0);
            check($sformatf("t6_not_busy%0d", c), 32'(busy), 0);
        end
        req_valid = 4'b1111;
        #1;
        check("t6_rr_restart", 32'(req_ready), 32'b0001);
        req_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
